// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first, with a registered carry.
// Optional subtract mode (Sub port, S = A - B, Co = no borrow) is enabled by defining SERIAL_ADDER_SUB_EN.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// state   | meaning
// IDLE    | waiting for start; S/Co hold the last result
// ADD     | one operand bit per cycle through the cell
// DONE    | S/Co just updated; done pulse; start may be accepted here
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-2:0] SH_MSB   = (WIDTH-1)'(1) << (WIDTH - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only WIDTH-1 partial sum bits are stored; the last bit comes straight from the cell.
  logic [WIDTH-2:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic fa_s;
  logic fa_co;
  logic accept;

  fulladder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept = start && (state_q != ST_ADD);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_sh_d  = s_sh_q;
    s_d     = s_q;
    co_d    = co_q;

    case (state_q)
      ST_ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        s_sh_d  = (s_sh_q >> 1) | (fa_s ? SH_MSB : '0);
        if (cnt_q == CNT_LAST) begin
          s_d     = {fa_s, s_sh_q};
          co_d    = fa_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          a_sh_d  = A;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert B and force the carry-in.
          b_sh_d  = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
`else
          b_sh_d  = B;
          carry_d = Cin;
`endif
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_sh_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_sh_q  <= s_sh_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Co   = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operands against an arithmetic model.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic             Sub = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub   (Sub),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Co    (Co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, {carry, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sub);
    logic [WIDTH:0] r;
    if (sub) begin
      r[WIDTH-1:0] = a - b;
      r[WIDTH]     = (a >= b);
    end else begin
      r = a + b + cin;
    end
    return r;
  endfunction

  // mode 0: single start pulse; 1: start held high; 2: stray starts during cycles 3 and 5
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int mode);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] s_prev;
    logic             co_prev;
    exp     = model(a, b, cin, sub);
    s_prev  = S;
    co_prev = Co;
    A = a; B = b; Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    Sub = sub;
`endif
    start = 1'b1;
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      chk("busy_in_add", busy, 1);
      chk("done_in_add", done, 0);
      chk("S_hold_in_add", S, s_prev);
      chk("Co_hold_in_add", Co, co_prev);
      A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      Sub = 1'($urandom);
`endif
      if (mode == 1)      start = 1'b1;
      else if (mode == 2) start = (i + 1 == 3) || (i + 1 == 5);
      else                start = 1'b0;
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("S_result", S, exp[WIDTH-1:0]);
    chk("Co_result", Co, exp[WIDTH]);
    if (mode != 1) begin
      tick();
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("S_held_after", S, exp[WIDTH-1:0]);
      chk("Co_held_after", Co, exp[WIDTH]);
    end
  endtask

  initial begin
    int t0;
    logic [WIDTH-1:0] ra, rb;
    logic rc, rs;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_Co", Co, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);

    // Back-to-back with start held high; second accept happens in the DONE cycle
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1);
    t0 = cyc;
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1);
    chk("done_period", 64'(cyc - t0), 64'(WIDTH + 1));
    start = 1'b0;
    tick();
    chk("b2b_done_drop", done, 0);
    chk("b2b_busy_drop", busy, 0);

    run_op(8'h33, 8'h44, 1'b1, 1'b0, 2);
    for (int i = 0; i < WIDTH + 2; i++) begin
      chk("no_extra_done", done, 0);
      tick();
    end

    // Abort mid-operation with reset at cycle 4 of ADD
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_S", S, 0);
    chk("abort_Co", Co, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 3; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
      tick();
    end
    run_op(8'hC8, 8'h64, 1'b1, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)) == 2 ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that reuses a single `fulladder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. It accepts a start request and latches the operands. It sequences the cell through WIDTH cycles with a registered carry, then presents the sum and carry-out with a one-cycle done pulse. It is the area-minimal alternative to the ripple-carry/parallel adders in the same adder library.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request to begin an addition; sampled on rising edge
A  input  WIDTH  operand A; sampled only on the accepting edge
B  input  WIDTH  operand B; sampled only on the accepting edge
Cin  input  1  carry-in; sampled only on the accepting edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when S/Co become valid
S  output  WIDTH  sum result; held until the next accepted start
Co  output  1  final carry-out; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0; done=0; S=0; Co=0; operand shift registers, carry register and bit counter all cleared. Reset asserted mid-operation aborts the operation; no done pulse is produced.
- Datapath:
  - Exactly one `fulladder` instance, combinational.
  - Its inputs are A_sh[0], B_sh[0] and carry_q.
  - Each ADD cycle: sum bit shifts into S_sh at the MSB end; A_sh and B_sh shift right by 1; carry_q <= cell Co.
- States:
  - IDLE: busy=0. start=1 -> accept: load A_sh<=A, B_sh<=B, carry_q<=Cin, cnt<=0; go to ADD.
  - ADD: busy=1. Processes one bit per cycle; cnt increments. When cnt==WIDTH-1 on that edge: S<=final shifted sum, Co<=cell Co; go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 here is accepted as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency:
  - Accepting edge at cycle 0; ADD occupies cycles 1..WIDTH.
  - done=1 and S/Co valid during cycle WIDTH+1.
  - Minimum start-to-start period is WIDTH+1 cycles.
- start while busy=1 is ignored: no re-latch and no effect on the result.
- A, B and Cin changes after acceptance have no effect.
- S and Co change only at the final ADD edge and at reset. They are stable from done until the next completion.
- Counter width is $clog2(WIDTH); there is no wrap beyond WIDTH-1 within one operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Extra input port Sub (1 bit), sampled on the accepting edge.
  - Sub=1 loads B_sh<=~B and carry_q<=1, ignoring Cin. Result is S=A-B mod 2^WIDTH; Co=1 means no borrow (A>=B unsigned).
  - Sub=0 behaves identically to the base block.
- When undefined: no Sub port; addition only.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, start pulse -> busy high for 8 cycles; done at cycle 9; S=0x96, Co=0.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Co=1. Then A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Co=1.
- Hold start high continuously with operand pairs (0x01,0x01), (0x80,0x80) -> results 0x02/Co=0 then 0x00/Co=1; second start accepted in the DONE cycle; done pulses exactly 9 cycles apart.
- start asserted at cycles 3 and 5 of an ADD with different A/B -> ignored; original result delivered; no extra done.
- rst_n pulled low at cycle 4 of an ADD -> busy, done, S, Co = 0 immediately; no done follows; next start computes correctly.
- SERIAL_ADDER_SUB_EN defined, Sub=1:
  - A=0x10, B=0x01 -> S=0x0F, Co=1.
  - A=0x01, B=0x02 -> S=0xFF, Co=0.
